// File: rtl/dual_req_scheduler.sv
// Request-holding and two-slot grant stage around an external dual priority decoder.
// Pending requests feed the decoder; its top two indices are loaded into valid/ready grant slots.
module dual_req_scheduler #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_set,
    output logic [N-1:0]  pend,
    input  logic [IW-1:0] dec_idx1,
    input  logic          dec_v1,
    input  logic [IW-1:0] dec_idx2,
    input  logic          dec_v2,
    output logic          g1_valid,
    output logic [IW-1:0] g1_idx,
    input  logic          g1_ready,
    output logic          g2_valid,
    output logic [IW-1:0] g2_idx,
    input  logic          g2_ready,
    output logic          idle
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t   slot1_st;
    slot_state_t   slot2_st;
    logic [N-1:0]  pending;
    logic [N-1:0]  inflight;

    logic          free1;
    logic          free2;
    logic          accept1;
    logic          accept2;
    logic          load1;
    logic          load2;
    logic [IW-1:0] load1_idx;
    logic [IW-1:0] load2_idx;
    logic [N-1:0]  load_mask;
    logic [N-1:0]  accept_mask;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] oh;
        for (int k = 0; k < N; k++) begin
            oh[k] = (i == IW'(k));
        end
        return oh;
    endfunction

    assign g1_valid = (slot1_st == SLOT_FULL);
    assign g2_valid = (slot2_st == SLOT_FULL);

    // In-flight indices are hidden from the decoder so no index can occupy both slots.
    assign pend = pending & ~inflight;
    assign idle = (pending == '0) && !g1_valid && !g2_valid;

    assign accept1 = g1_valid && g1_ready;
    assign accept2 = g2_valid && g2_ready;
    assign free1   = !g1_valid || g1_ready;
    assign free2   = !g2_valid || g2_ready;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        load1     = 1'b0;
        load2     = 1'b0;
        load1_idx = dec_idx1;
        load2_idx = dec_idx2;
        if (free1 && free2) begin
            load1 = dec_v1;
            load2 = dec_v2;
        end else if (free1) begin
            load1 = dec_v1;
        end else if (free2) begin
            // Only slot 2 can take a grant: it gets the highest-priority candidate.
            load2     = dec_v1;
            load2_idx = dec_idx1;
        end
    end

    always_comb begin
        load_mask   = '0;
        accept_mask = '0;
        if (load1)   load_mask   = load_mask   | onehot(load1_idx);
        if (load2)   load_mask   = load_mask   | onehot(load2_idx);
        if (accept1) accept_mask = accept_mask | onehot(g1_idx);
        if (accept2) accept_mask = accept_mask | onehot(g2_idx);
    end

    // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            inflight <= '0;
            slot1_st <= SLOT_EMPTY;
            slot2_st <= SLOT_EMPTY;
            g1_idx   <= '0;
            g2_idx   <= '0;
        end else begin
            // A same-cycle request wins over the clear caused by loading that index.
            pending  <= (pending & ~load_mask) | req_set;
            inflight <= (inflight & ~accept_mask) | load_mask;

            if (load1) begin
                slot1_st <= SLOT_FULL;
                g1_idx   <= load1_idx;
            end else if (accept1) begin
                slot1_st <= SLOT_EMPTY;
            end

            if (load2) begin
                slot2_st <= SLOT_FULL;
                g2_idx   <= load2_idx;
            end else if (accept2) begin
                slot2_st <= SLOT_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_dual_req_scheduler.sv
// Bench for dual_req_scheduler: directed scenarios plus random traffic, checked against
// a candidate-list reference model; a small priority decoder closes the loop around the DUT.
module tb_dual_req_scheduler;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_set;
    logic [N-1:0]  pend;
    logic [IW-1:0] dec_idx1;
    logic          dec_v1;
    logic [IW-1:0] dec_idx2;
    logic          dec_v2;
    logic          g1_valid;
    logic [IW-1:0] g1_idx;
    logic          g1_ready;
    logic          g2_valid;
    logic [IW-1:0] g2_idx;
    logic          g2_ready;
    logic          idle;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, as seen just after the next rising edge.
    logic [N-1:0]  m_pending;
    logic [N-1:0]  m_inflight;
    logic          m_v   [2];
    logic [IW-1:0] m_idx [2];

    always #5 clk = ~clk;

    dual_req_scheduler #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_set  (req_set),
        .pend     (pend),
        .dec_idx1 (dec_idx1),
        .dec_v1   (dec_v1),
        .dec_idx2 (dec_idx2),
        .dec_v2   (dec_v2),
        .g1_valid (g1_valid),
        .g1_idx   (g1_idx),
        .g1_ready (g1_ready),
        .g2_valid (g2_valid),
        .g2_idx   (g2_idx),
        .g2_ready (g2_ready),
        .idle     (idle)
    );

    // Dual priority decoder: highest and second-highest set bit of pend.
    always_comb begin
        dec_v1   = 1'b0;
        dec_v2   = 1'b0;
        dec_idx1 = '0;
        dec_idx2 = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                dec_idx2 = dec_idx1;
                dec_v2   = dec_v1;
                dec_idx1 = IW'(i);
                dec_v1   = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Advance the model by one clock edge using the inputs applied for that edge.
    task automatic model_step(input logic rst, input logic [N-1:0] rs, input logic r1, input logic r2);
        int   cands[$];
        logic rdy  [2];
        logic free [2];
        int   next_c;
        if (!rst) begin
            m_pending  = '0;
            m_inflight = '0;
            m_v[0] = 1'b0; m_v[1] = 1'b0;
            m_idx[0] = '0; m_idx[1] = '0;
            return;
        end
        rdy[0] = r1;
        rdy[1] = r2;
        // Candidates in priority order: waiting requests not currently held by a slot.
        for (int i = N - 1; i >= 0; i--)
            if (m_pending[i] && !m_inflight[i]) cands.push_back(i);
        for (int s = 0; s < 2; s++) begin
            free[s] = !m_v[s] || rdy[s];
            if (m_v[s] && rdy[s]) begin
                m_inflight[m_idx[s]] = 1'b0;
                m_v[s] = 1'b0;
            end
        end
        next_c = 0;
        for (int s = 0; s < 2; s++) begin
            if (free[s] && next_c < cands.size()) begin
                m_v[s]   = 1'b1;
                m_idx[s] = IW'(cands[next_c]);
                m_inflight[cands[next_c]] = 1'b1;
                m_pending[cands[next_c]]  = 1'b0;
                next_c++;
            end
        end
        m_pending = m_pending | rs;
    endtask

    task automatic step(input logic rst, input logic [N-1:0] rs, input logic r1, input logic r2);
        @(negedge clk);
        rst_n    = rst;
        req_set  = rs;
        g1_ready = r1;
        g2_ready = r2;
        model_step(rst, rs, r1, r2);
        @(posedge clk);
        #1;
        check("pend", 32'(pend), 32'(m_pending & ~m_inflight));
        check("g1_valid", 32'(g1_valid), 32'(m_v[0]));
        check("g2_valid", 32'(g2_valid), 32'(m_v[1]));
        check("idle", 32'(idle), 32'((m_pending == '0) && !m_v[0] && !m_v[1]));
        if (m_v[0]) check("g1_idx", 32'(g1_idx), 32'(m_idx[0]));
        if (m_v[1]) check("g2_idx", 32'(g2_idx), 32'(m_idx[1]));
    endtask

    initial begin
        rst_n    = 1'b0;
        req_set  = '0;
        g1_ready = 1'b0;
        g2_ready = 1'b0;
        model_step(1'b0, '0, 1'b0, 1'b0);

        // 1. Reset holds everything clear even with requests present.
        step(1'b0, 4'b1111, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 1'b0);
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_g1_idx", 32'(g1_idx), 32'd0);
        check("rst_g2_idx", 32'(g2_idx), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        // 2. Two requests granted two edges later, then retired together.
        step(1'b1, 4'b1010, 1'b1, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        check("lat_g1_idx", 32'(g1_idx), 32'd3);
        check("lat_g2_idx", 32'(g2_idx), 32'd1);
        check("lat_both_valid", 32'({g1_valid, g2_valid}), 32'b11);
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        check("drain_valid", 32'({g1_valid, g2_valid}), 32'b00);
        check("drain_idle", 32'(idle), 32'd1);

        // 3. Back-pressured slot 1 stays stable; slot 2 takes the next request.
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("hold_g1_idx", 32'(g1_idx), 32'd3);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("slot2_idx", 32'(g2_idx), 32'd2);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("g1_retired", 32'(g1_valid), 32'd0);
        step(1'b1, 4'b0000, 1'b1, 1'b1);

        // 4. Re-request of an in-flight index stays masked until accept, then re-grants.
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        check("masked_pend", 32'(pend), 32'd0);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("unmasked_pend", 32'(pend), 32'b0100);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("regrant_idx", 32'(g1_idx), 32'd2);
        check("regrant_valid", 32'(g1_valid), 32'd1);

        // 5. Slot 1 blocked; slot 2 alone takes the highest candidate each time.
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("s5_g2_first", 32'(g2_idx), 32'd2);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check("s5_g2_second", 32'(g2_idx), 32'd1);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("s5_g1_empty", 32'(g1_valid), 32'd0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check("s5_idle", 32'(idle), 32'd1);

        // 6. Reset with both slots full and a request waiting drops everything.
        step(1'b1, 4'b1100, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b1, 1'b1);
        check("s6_no_grant", 32'({g1_valid, g2_valid}), 32'b00);
        check("s6_idle", 32'(idle), 32'd1);

        // Random traffic with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) != 0),
                 N'($urandom & $urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
